// File: rtl/gpio_out_port.sv
// gpio_out_port: memory-mapped GPIO output register with plain write, set,
// clear and toggle access, a registered read port and an optional pulse
// engine that inverts masked pins for a programmed number of cycles.
// Optional feature macro: GPIO_PULSE_EN (pulse engine, PULSE register and
// STATUS bits). Without it, PULSE writes are ignored and STATUS reads 0.
module gpio_out_port #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] GPIO_o,
  output logic             busy_o
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TGL    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      status_rd;
  logic             unused_wdata;

  assign wr_en        = sel & we;
  assign rd_en        = sel & ~we;
  assign wr_data      = wdata[WIDTH-1:0];
  // Upper store-data bits are don't-care for most registers.
  assign unused_wdata = ^wdata;

  // Output register update from OUT/SET/CLR/TGL stores.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    out_d = out_q;
    if (wr_en) begin
      case (addr)
        ADDR_OUT: out_d = wr_data;
        ADDR_SET: out_d = out_q | wr_data;
        ADDR_CLR: out_d = out_q & ~wr_data;
        ADDR_TGL: out_d = out_q ^ wr_data;
        default:  out_d = out_q;
      endcase
    end
  end

`ifdef GPIO_PULSE_EN
  localparam logic [2:0] ADDR_PULSE = 3'd4;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pulse_cnt;
  logic             done_set;

  assign pulse_cnt = wdata[WIDTH+CNT_W-1:WIDTH];

  // Pulse FSM: start on a valid PULSE write in IDLE, count down in ACTIVE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    done_d   = done_q;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en && addr == ADDR_PULSE && wr_data != '0 && pulse_cnt != '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = pulse_cnt;
          mask_d  = wr_data;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_IDLE;
          mask_d   = '0;
          done_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Write-1-clear first so a same-edge completion keeps done set.
    if (wr_en && addr == ADDR_STATUS && wdata[1]) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
  end

  // Pulse engine state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (state_q == ST_ACTIVE);
  assign GPIO_o    = out_q ^ (busy_o ? mask_q : '0);
  assign status_rd = 32'({done_q, busy_o});
`else
  assign busy_o    = 1'b0;
  assign GPIO_o    = out_q;
  assign status_rd = '0;
`endif

  // Read mux; rdata holds its last value when no load is in progress.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_OUT:    rdata_d = 32'(out_q);
        ADDR_STATUS: rdata_d = status_rd;
        default:     rdata_d = '0;
      endcase
    end
  end

  // Output and read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      out_q   <= RESET_VAL;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_gpio_out_port.sv
// Self-checking bench for gpio_out_port: directed literal checks plus a
// randomized phase compared every cycle against an end-time based model.
module tb_gpio_out_port;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  GPIO_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  gpio_out_port #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .GPIO_o(GPIO_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pulse tracked by the edge index at which it ends: busy after edge e
  // means e < p_end.
  int unsigned cyc;
  int unsigned p_end;
  logic [7:0]  m_out;
  logic [7:0]  m_mask;
  logic        m_done;
  logic [31:0] m_rdata;
  bit          model_on = 0;

  task automatic model_reset();
    cyc     = 0;
    p_end   = 0;
    m_out   = 8'hA5;
    m_mask  = 8'h00;
    m_done  = 1'b0;
    m_rdata = 32'h0;
  endtask

  task automatic model_step();
    int unsigned e;
    bit          pre_busy;
    logic [7:0]  d;
    int unsigned c;
    e        = cyc + 1;
    pre_busy = (cyc < p_end);
    d        = wdata[7:0];
    c        = int'(wdata[23:8]);
    if (sel && !we) begin
      case (addr)
        3'd0:    m_rdata = {24'h0, m_out};
`ifdef GPIO_PULSE_EN
        3'd5:    m_rdata = {30'h0, m_done, pre_busy};
`endif
        default: m_rdata = 32'h0;
      endcase
    end
    if (sel && we) begin
      case (addr)
        3'd0: m_out = d;
        3'd1: m_out = m_out | d;
        3'd2: m_out = m_out & ~d;
        3'd3: m_out = m_out ^ d;
`ifdef GPIO_PULSE_EN
        3'd4: if (!pre_busy && d != 8'h00 && c != 0) begin
                m_mask = d;
                p_end  = e + c;
              end
        3'd5: if (wdata[1]) m_done = 1'b0;
`endif
        default: ;
      endcase
    end
`ifdef GPIO_PULSE_EN
    if (pre_busy && e == p_end) m_done = 1'b1;
`endif
    cyc = e;
  endtask

  function automatic logic exp_busy();
`ifdef GPIO_PULSE_EN
    return (cyc < p_end);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_gpio();
    return m_out ^ (exp_busy() ? m_mask : 8'h00);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Compare process: outputs checked against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("cyc_gpio",  {24'h0, GPIO_o}, {24'h0, exp_gpio()});
        check("cyc_busy",  {31'h0, busy_o}, {31'h0, exp_busy()});
        check("cyc_rdata", rdata, m_rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    sel = 1'b1; we = 1'b0; addr = a; wdata = 32'h0;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic async_reset_pulse(input string name);
    #2 rst = 1'b0;
    #1;
    check({name, "_gpio"}, {24'h0, GPIO_o}, 32'h0000_00A5);
    check({name, "_busy"}, {31'h0, busy_o}, 32'h0);
    check({name, "_rdata"}, rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_gpio",  {24'h0, GPIO_o}, 32'h0000_00A5);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy",  {31'h0, busy_o}, 32'h0);
    rst = 1'b1;
    model_on = 1;
    @(negedge clk);

    // Plain register operations, upper data bits must be ignored.
    bus_wr(3'd0, 32'hFFFF_FF3C); check("wr_out", {24'h0, GPIO_o}, 32'h3C);
    bus_wr(3'd1, 32'h0000_0001); check("wr_set", {24'h0, GPIO_o}, 32'h3D);
    bus_wr(3'd2, 32'h0000_000C); check("wr_clr", {24'h0, GPIO_o}, 32'h31);
    bus_wr(3'd3, 32'h0000_00F0); check("wr_tgl", {24'h0, GPIO_o}, 32'hC1);
    bus_rd(3'd0);                check("rd_out", rdata, 32'h0000_00C1);
    bus_rd(3'd1);                check("rd_set_zero", rdata, 32'h0);
    bus_rd(3'd0);
    bus_rd(3'd7);                check("rd_rsvd_zero", rdata, 32'h0);
    bus_wr(3'd6, 32'hFFFF_FFFF); check("wr_rsvd_ign", {24'h0, GPIO_o}, 32'hC1);

    // Asynchronous reset between edges.
    async_reset_pulse("async_rst");
    @(negedge clk);

`ifdef GPIO_PULSE_EN
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd4, 32'h0000_0581);
    for (int i = 0; i < 5; i++) begin
      check("p5_gpio", {24'h0, GPIO_o}, 32'h81);
      check("p5_busy", {31'h0, busy_o}, 32'h1);
      @(negedge clk);
    end
    check("p5_end_gpio", {24'h0, GPIO_o}, 32'h00);
    check("p5_end_busy", {31'h0, busy_o}, 32'h0);
    bus_rd(3'd5);                check("p5_status_done", rdata, 32'h2);
    bus_wr(3'd5, 32'h2);
    bus_rd(3'd5);                check("p5_status_clr", rdata, 32'h0);

    bus_wr(3'd4, 32'h0000_0A81);
    bus_wr(3'd4, 32'h0003_01FF);
    bus_wr(3'd1, 32'h0000_0002); check("p10_set", {24'h0, GPIO_o}, 32'h83);
    for (int i = 0; i < 20 && busy_o; i++) begin
      check("p10_hold", {24'h0, GPIO_o}, 32'h83);
      @(negedge clk);
    end
    check("p10_end_busy", {31'h0, busy_o}, 32'h0);
    check("p10_end_gpio", {24'h0, GPIO_o}, 32'h02);

    bus_wr(3'd4, 32'h0000_00FF); check("p_cnt0_busy", {31'h0, busy_o}, 32'h0);
    check("p_cnt0_gpio", {24'h0, GPIO_o}, 32'h02);
    bus_wr(3'd4, 32'h0000_0400); check("p_msk0_busy", {31'h0, busy_o}, 32'h0);
    check("p_msk0_gpio", {24'h0, GPIO_o}, 32'h02);

    bus_wr(3'd5, 32'h2);
    bus_wr(3'd4, 32'h0000_08F0);
    @(negedge clk);
    async_reset_pulse("p8_rst");
    bus_rd(3'd5);                check("p8_rst_done", rdata, 32'h0);
`else
    bus_wr(3'd4, 32'h0000_04FF); check("nopulse_busy", {31'h0, busy_o}, 32'h0);
    check("nopulse_gpio", {24'h0, GPIO_o}, 32'hA5);
    @(negedge clk);
    check("nopulse_gpio2", {24'h0, GPIO_o}, 32'hA5);
    bus_rd(3'd5);                check("nopulse_status", rdata, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      sel   = ($urandom_range(0, 9) < 7);
      we    = $urandom_range(0, 1) == 1;
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if (addr == 3'd4) begin
        wdata[23:8] = 16'($urandom_range(0, 12));
        if ($urandom_range(0, 3) == 0) wdata[7:0] = 8'h00;
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse("rnd_rst");
      end else begin
        @(negedge clk);
      end
    end
    sel = 1'b0; we = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
